// File: rtl/ahb_bus_arbiter.sv
// AHB bus arbiter: round-robin grant of one AHB bus among NUM_MASTERS masters, with burst tracking, locked transfers and parking.
// Latency: HGRANT updates one edge after an arbitration point; HMASTER/HMASTLOCK follow on the next accepted address phase.
// Backpressure: HREADY=0 freezes every register. Optional build macro AHB_ARB_FIXED_PRIO_EN selects fixed lowest-index priority.
module ahb_bus_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int MASTER_ID_W    = 2,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                   CLK_ARBITER,
    input  logic                   RESET_ARBITER,
    input  logic [NUM_MASTERS-1:0] HBUSREQ,
    input  logic [NUM_MASTERS-1:0] HLOCK,
    input  logic                   HREADY,
    input  logic [1:0]             HTRANS,
    input  logic [2:0]             HBURST,
    output logic [NUM_MASTERS-1:0] HGRANT,
    output logic [MASTER_ID_W-1:0] HMASTER,
    output logic                   HMASTLOCK,
    output logic                   arb_burst_busy
);

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BURST  = 2'd1,
        ARB_LOCKED = 2'd2
    } arb_state_t;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    localparam logic [NUM_MASTERS-1:0] PARK_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;
    localparam logic [MASTER_ID_W-1:0] PARK_ID    = MASTER_ID_W'(DEFAULT_MASTER);

    arb_state_t             state_q, state_d;
    logic [NUM_MASTERS-1:0] hgrant_q, hgrant_d;
    logic [MASTER_ID_W-1:0] hmaster_q;
    logic                   hmastlock_q;
    logic [3:0]             beat_cnt_q, beat_cnt_d;
    logic [MASTER_ID_W-1:0] rr_last_q, rr_last_d;

    logic [MASTER_ID_W-1:0] owner_idx;
    logic                   owner_req;
    logic                   owner_lock;
    logic                   is_nonseq;
    logic                   is_seq;
    logic                   fixed_burst;
    logic [3:0]             len_m1;
    logic                   arb_point;
    logic                   win_found;
    logic [MASTER_ID_W-1:0] win_idx;

    // Owner is whichever master currently holds the one-hot grant
    always_comb begin
        owner_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (hgrant_q[i]) begin
                owner_idx = MASTER_ID_W'(i);
            end
        end
    end

    assign owner_req  = HBUSREQ[owner_idx];
    assign owner_lock = HLOCK[owner_idx];
    assign is_nonseq  = (HTRANS == TR_NONSEQ);
    assign is_seq     = (HTRANS == TR_SEQ);
    assign fixed_burst = (HBURST[2:1] != 2'b00);

    // Burst length minus one; SINGLE and INCR carry no beat count
    always_comb begin
        case (HBURST[2:1])
            2'b01:   len_m1 = 4'd3;
            2'b10:   len_m1 = 4'd7;
            2'b11:   len_m1 = 4'd15;
            default: len_m1 = 4'd0;
        endcase
    end

    // Arbitration point: an accepted transfer after which the bus may change hands
    always_comb begin
        arb_point = 1'b0;
        if (HREADY) begin
            if (HTRANS == TR_IDLE) begin
                arb_point = 1'b1;
            end else if (is_nonseq && (HBURST == 3'b000)) begin
                arb_point = 1'b1;
            end else if ((is_nonseq || is_seq) && (HBURST == 3'b001) && !owner_req) begin
                arb_point = 1'b1;
            end else if (is_seq && (beat_cnt_q == 4'd1)) begin
                arb_point = 1'b1;
            end
        end
    end

`ifdef AHB_ARB_FIXED_PRIO_EN
    // Fixed priority: lowest-index requester wins, the owner included
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (HBUSREQ[i]) begin
                win_found = 1'b1;
                win_idx   = MASTER_ID_W'(i);
            end
        end
    end
`else
    logic [NUM_MASTERS-1:0] req_others;
    logic [MASTER_ID_W-1:0] cand;

    assign req_others = HBUSREQ & ~hgrant_q;

    // Round-robin search after rr_last; the owner only wins when nobody else asks
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            cand = MASTER_ID_W'((int'(rr_last_q) + k) % NUM_MASTERS);
            if (!win_found && req_others[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        if (!win_found && owner_req) begin
            win_found = 1'b1;
            win_idx   = owner_idx;
        end
    end
`endif

    // Next grant, round-robin pointer and beat counter
    always_comb begin
        hgrant_d   = hgrant_q;
        rr_last_d  = rr_last_q;
        beat_cnt_d = beat_cnt_q;
        if (HREADY) begin
            if (is_nonseq) begin
                beat_cnt_d = len_m1;
            end else if (is_seq && (beat_cnt_q != 4'd0)) begin
                beat_cnt_d = beat_cnt_q - 4'd1;
            end
        end
        if (arb_point && !owner_lock) begin
            if (win_found) begin
                hgrant_d  = NUM_MASTERS'(1) << win_idx;
                rr_last_d = win_idx;
            end else begin
                hgrant_d = PARK_GRANT;
            end
        end
    end

    // FSM state register
    always_ff @(posedge CLK_ARBITER or negedge RESET_ARBITER) begin
        if (!RESET_ARBITER) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: arbitration points settle lock, fixed NONSEQ opens a burst
    always_comb begin
        state_d = state_q;
        if (HREADY) begin
            if (arb_point) begin
                state_d = owner_lock ? ARB_LOCKED : ARB_IDLE;
            end else if (is_nonseq && fixed_burst) begin
                state_d = ARB_BURST;
            end
        end
    end

    // FSM output
    always_comb begin
        arb_burst_busy = (state_q == ARB_BURST);
    end

    // Grant, address-phase owner and lock registers; all frozen while HREADY is low
    always_ff @(posedge CLK_ARBITER or negedge RESET_ARBITER) begin
        if (!RESET_ARBITER) begin
            hgrant_q    <= PARK_GRANT;
            hmaster_q   <= PARK_ID;
            hmastlock_q <= 1'b0;
            beat_cnt_q  <= 4'd0;
            rr_last_q   <= PARK_ID;
        end else if (HREADY) begin
            hgrant_q    <= hgrant_d;
            hmaster_q   <= owner_idx;
            hmastlock_q <= owner_lock;
            beat_cnt_q  <= beat_cnt_d;
            rr_last_q   <= rr_last_d;
        end
    end

    assign HGRANT    = hgrant_q;
    assign HMASTER   = hmaster_q;
    assign HMASTLOCK = hmastlock_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed testbench for ahb_bus_arbiter (default round-robin build, 4 masters, park on master 0).
// Vectors are applied one per clock; outputs are compared 1ns after the rising edge.
// Hand-written sequences cover reset state and asynchronous reset in the middle of a locked burst.
module tb_ahb_bus_arbiter;

    localparam logic [1:0] I = 2'b00, B = 2'b01, N = 2'b10, S = 2'b11;
    localparam logic [2:0] SGL = 3'b000, INC = 3'b001, I4 = 3'b010, I8 = 3'b100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] hbusreq = '0;
    logic [3:0] hlock = '0;
    logic       hready = 1'b1;
    logic [1:0] htrans = I;
    logic [2:0] hburst = SGL;
    logic [3:0] hgrant;
    logic [1:0] hmaster;
    logic       hmastlock;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0] req;
        logic [3:0] lock;
        logic       rdy;
        logic [1:0] tr;
        logic [2:0] bu;
        logic [3:0] g;
        logic [1:0] m;
        logic       l;
        logic       b;
    } vec_t;

    vec_t vt[$];

    ahb_bus_arbiter #(
        .NUM_MASTERS(4),
        .MASTER_ID_W(2),
        .DEFAULT_MASTER(0)
    ) dut (
        .CLK_ARBITER(clk),
        .RESET_ARBITER(rst_n),
        .HBUSREQ(hbusreq),
        .HLOCK(hlock),
        .HREADY(hready),
        .HTRANS(htrans),
        .HBURST(hburst),
        .HGRANT(hgrant),
        .HMASTER(hmaster),
        .HMASTLOCK(hmastlock),
        .arb_burst_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] g, input logic [1:0] m,
                           input logic l, input logic b);
        chk({tag, ".HGRANT"}, 32'(hgrant), 32'(g));
        chk({tag, ".HMASTER"}, 32'(hmaster), 32'(m));
        chk({tag, ".HMASTLOCK"}, 32'(hmastlock), 32'(l));
        chk({tag, ".busy"}, 32'(busy), 32'(b));
    endtask

    task automatic add(input logic [3:0] req, input logic [3:0] lock, input logic rdy,
                       input logic [1:0] tr, input logic [2:0] bu, input logic [3:0] g,
                       input logic [1:0] m, input logic l, input logic b);
        vec_t v;
        v.req = req; v.lock = lock; v.rdy = rdy; v.tr = tr; v.bu = bu;
        v.g = g; v.m = m; v.l = l; v.b = b;
        vt.push_back(v);
    endtask

    task automatic drive(input logic [3:0] req, input logic [3:0] lock, input logic rdy,
                         input logic [1:0] tr, input logic [2:0] bu);
        hbusreq = req; hlock = lock; hready = rdy; htrans = tr; hburst = bu;
    endtask

    initial begin
        // Single request while idle, then parking
        add(4'b0100, 4'b0000, 1, I, SGL, 4'b0100, 2'd0, 0, 0);
        add(4'b0000, 4'b0000, 1, I, SGL, 4'b0001, 2'd2, 0, 0);
        add(4'b0000, 4'b0000, 1, I, SGL, 4'b0001, 2'd0, 0, 0);
        // M1 INCR4, M3 requests from beat 2, handover only after beat 4
        add(4'b0010, 4'b0000, 1, I, SGL, 4'b0010, 2'd0, 0, 0);
        add(4'b0010, 4'b0000, 1, N, I4,  4'b0010, 2'd1, 0, 1);
        add(4'b1010, 4'b0000, 1, S, I4,  4'b0010, 2'd1, 0, 1);
        add(4'b1010, 4'b0000, 1, S, I4,  4'b0010, 2'd1, 0, 1);
        add(4'b1010, 4'b0000, 1, S, I4,  4'b1000, 2'd1, 0, 0);
        add(4'b0000, 4'b0000, 1, I, SGL, 4'b0001, 2'd3, 0, 0);
        // All request, SINGLE transfers: order 1,2,3,0,1
        add(4'b1111, 4'b0000, 1, N, SGL, 4'b0010, 2'd0, 0, 0);
        add(4'b1111, 4'b0000, 1, N, SGL, 4'b0100, 2'd1, 0, 0);
        add(4'b1111, 4'b0000, 1, N, SGL, 4'b1000, 2'd2, 0, 0);
        add(4'b1111, 4'b0000, 1, N, SGL, 4'b0001, 2'd3, 0, 0);
        add(4'b1111, 4'b0000, 1, N, SGL, 4'b0010, 2'd0, 0, 0);
        // M2 locked INCR8 with a 3-cycle HREADY stall, lock kept then released
        add(4'b0100, 4'b0100, 1, I, SGL, 4'b0100, 2'd1, 0, 0);
        add(4'b0100, 4'b0100, 1, N, I8,  4'b0100, 2'd2, 1, 1);
        add(4'b0101, 4'b0100, 1, S, I8,  4'b0100, 2'd2, 1, 1);
        for (int i = 0; i < 3; i++) add(4'b1011, 4'b0100, 0, I, SGL, 4'b0100, 2'd2, 1, 1);
        for (int i = 0; i < 5; i++) add(4'b1011, 4'b0100, 1, S, I8, 4'b0100, 2'd2, 1, 1);
        add(4'b1011, 4'b0100, 1, S, I8,  4'b0100, 2'd2, 1, 0);
        add(4'b1011, 4'b0100, 1, I, SGL, 4'b0100, 2'd2, 1, 0);
        add(4'b1011, 4'b0000, 1, I, SGL, 4'b1000, 2'd2, 0, 0);
        add(4'b0000, 4'b0000, 1, I, SGL, 4'b0001, 2'd3, 0, 0);
        // INCR8 cut short by NONSEQ SINGLE after beat 3
        add(4'b0001, 4'b0000, 1, N, I8,  4'b0001, 2'd0, 0, 1);
        add(4'b0001, 4'b0000, 1, S, I8,  4'b0001, 2'd0, 0, 1);
        add(4'b0001, 4'b0000, 1, S, I8,  4'b0001, 2'd0, 0, 1);
        add(4'b0001, 4'b0000, 1, N, SGL, 4'b0001, 2'd0, 0, 0);
        // Fresh INCR4 counts from its own length after the reload
        add(4'b0001, 4'b0000, 1, N, I4,  4'b0001, 2'd0, 0, 1);
        add(4'b0101, 4'b0000, 1, S, I4,  4'b0001, 2'd0, 0, 1);
        add(4'b0101, 4'b0000, 1, S, I4,  4'b0001, 2'd0, 0, 1);
        add(4'b0101, 4'b0000, 1, S, I4,  4'b0100, 2'd0, 0, 0);
        add(4'b0000, 4'b0000, 1, I, SGL, 4'b0001, 2'd2, 0, 0);
        // INCR holds the bus while the owner requests; BUSY is not an arbitration point
        add(4'b0011, 4'b0000, 1, N, INC, 4'b0001, 2'd0, 0, 0);
        add(4'b0010, 4'b0000, 1, S, INC, 4'b0010, 2'd0, 0, 0);
        add(4'b0001, 4'b0000, 1, B, INC, 4'b0010, 2'd1, 0, 0);
        add(4'b0001, 4'b0000, 1, I, SGL, 4'b0001, 2'd1, 0, 0);

        // Reset state
        #7;
        chk_all("reset", 4'b0001, 2'd0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vt[i]) begin
            drive(vt[i].req, vt[i].lock, vt[i].rdy, vt[i].tr, vt[i].bu);
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), vt[i].g, vt[i].m, vt[i].l, vt[i].b);
        end

        // Asynchronous reset in the middle of a locked burst
        drive(4'b0100, 4'b0100, 1, I, SGL);
        @(posedge clk); #1;
        chk_all("pre_rst_grant", 4'b0100, 2'd0, 0, 0);
        drive(4'b0100, 4'b0100, 1, N, I4);
        @(posedge clk); #1;
        chk_all("pre_rst_burst", 4'b0100, 2'd2, 1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 4'b0001, 2'd0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'b0000, 4'b0000, 1, S, I4);
        @(posedge clk); #1;
        chk_all("post_rst_seq", 4'b0001, 2'd0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
